// File: rtl/gsu_addr_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : gsu_addr_pipe_if
// Brief    : SNES-bus, window-config and ownership signals of gsu_addr_pipe.
// Revision : 1.0
// ============================================================================
interface gsu_addr_pipe_if #(
    parameter int NUM_WIN   = 4,
    parameter int WIN_IDX_W = 2
);
    logic [23:0]          snes_addr;
    logic                 snes_addr_stb;
    logic                 snes_romsel;
    logic [23:0]          saveram_mask;
    logic [23:0]          rom_mask;
    logic                 cfg_we;
    logic [WIN_IDX_W-1:0] cfg_idx;
    logic [23:0]          cfg_base;
    logic [23:0]          cfg_cmpmask;
    logic                 cfg_en;
    logic                 cfg_ack;
    logic                 gsu_rom_req;
    logic                 gsu_ram_req;
    logic                 bus_idle;
    logic                 gsu_rom_gnt;
    logic                 gsu_ram_gnt;
    logic                 out_valid;
    logic [23:0]          rom_addr;
    logic                 rom_hit;
    logic                 is_rom;
    logic                 is_saveram;
    logic                 is_writable;
    logic [NUM_WIN-1:0]   win_hit;
    logic                 snes_blocked;

    modport master (
        output snes_addr, snes_addr_stb, snes_romsel, saveram_mask, rom_mask,
        output cfg_we, cfg_idx, cfg_base, cfg_cmpmask, cfg_en,
        output gsu_rom_req, gsu_ram_req, bus_idle,
        input  cfg_ack, gsu_rom_gnt, gsu_ram_gnt, out_valid, rom_addr, rom_hit,
        input  is_rom, is_saveram, is_writable, win_hit, snes_blocked
    );

    modport slave (
        input  snes_addr, snes_addr_stb, snes_romsel, saveram_mask, rom_mask,
        input  cfg_we, cfg_idx, cfg_base, cfg_cmpmask, cfg_en,
        input  gsu_rom_req, gsu_ram_req, bus_idle,
        output cfg_ack, gsu_rom_gnt, gsu_ram_gnt, out_valid, rom_addr, rom_hit,
        output is_rom, is_saveram, is_writable, win_hit, snes_blocked
    );
endinterface
`default_nettype wire

// File: rtl/gsu_addr_pipe.sv
`default_nettype none
// ============================================================================
// Module   : gsu_addr_pipe
// Brief    : Two-stage SNES address classifier and SRAM0 translator; the
//            GSU ROM/RAM ownership arbiters exist only with GSU_ADDR_ARB_EN.
// Revision : 1.0
// ============================================================================
module gsu_addr_pipe #(
    parameter int NUM_WIN   = 4,
    parameter int WIN_IDX_W = 2
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    gsu_addr_pipe_if.slave bus
);

    // ------------------------------------------------------------------ config
    logic [23:0]          win_base_q [NUM_WIN];
    logic [23:0]          win_mask_q [NUM_WIN];
    logic [NUM_WIN-1:0]   win_en_q;
    logic                 cfg_ack_q;
    logic [WIN_IDX_W-1:0] w_cfg_idx;

    assign w_cfg_idx = bus.cfg_idx;

    // Out-of-range indices match no window, so they are dropped but still acked.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                win_base_q[i] <= '0;
                win_mask_q[i] <= '0;
                win_en_q[i]   <= 1'b0;
            end
            cfg_ack_q <= 1'b0;
        end else begin
            cfg_ack_q <= bus.cfg_we;
            for (int i = 0; i < NUM_WIN; i++) begin
                if (bus.cfg_we && (32'(w_cfg_idx) == i)) begin
                    win_base_q[i] <= bus.cfg_base;
                    win_mask_q[i] <= bus.cfg_cmpmask;
                    win_en_q[i]   <= bus.cfg_en;
                end
            end
        end
    end

    // ------------------------------------------------------------------ stage 1
    logic [23:0]        w_a;
    logic               w_is_rom;
    logic               w_is_sram;
    logic [NUM_WIN-1:0] w_win_match;
    logic [NUM_WIN-1:0] w_win_sel;

    assign w_a       = bus.snes_addr;
    assign w_is_rom  = w_a[22] | w_a[15];
    assign w_is_sram = bus.saveram_mask[0] & ~bus.snes_romsel &
                       ((&w_a[22:21]) | (~w_a[22] & ~w_a[15] & (&w_a[14:13])));

    always_comb begin
        w_win_match = '0;
        w_win_sel   = '0;
        for (int i = 0; i < NUM_WIN; i++) begin
            w_win_match[i] = win_en_q[i] & (((w_a ^ win_base_q[i]) & win_mask_q[i]) == 24'd0);
        end
        // Scan high to low so the lowest matching index is the one left standing.
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if (w_win_match[i]) begin
                w_win_sel    = '0;
                w_win_sel[i] = 1'b1;
            end
        end
    end

    logic               s1_valid_q;
    logic [22:0]        s1_addr_q;
    logic               s1_is_rom_q;
    logic               s1_is_sram_q;
    logic [NUM_WIN-1:0] s1_win_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid_q   <= 1'b0;
            s1_addr_q    <= '0;
            s1_is_rom_q  <= 1'b0;
            s1_is_sram_q <= 1'b0;
            s1_win_q     <= '0;
        end else begin
            s1_valid_q <= bus.snes_addr_stb;
            if (bus.snes_addr_stb) begin
                s1_addr_q    <= w_a[22:0];
                s1_is_rom_q  <= w_is_rom;
                s1_is_sram_q <= w_is_sram;
                s1_win_q     <= w_win_sel;
            end
        end
    end

    // ------------------------------------------------------------------ stage 2
    logic [16:0] w_sram_off;
    logic [23:0] w_sram_addr;
    logic [23:0] w_rom_addr;
    logic [23:0] rom_addr_d;

    assign w_sram_off  = s1_addr_q[22] ? s1_addr_q[16:0]
                                       : {s1_addr_q[19:16], s1_addr_q[12:0]};
    assign w_sram_addr = 24'hE00000 + ({7'd0, w_sram_off} & bus.saveram_mask);
    assign w_rom_addr  = (s1_addr_q[22] ? {2'b00, s1_addr_q[21:0]}
                                        : {2'b00, s1_addr_q[22:16], s1_addr_q[14:0]}) & bus.rom_mask;
    assign rom_addr_d  = s1_is_sram_q ? w_sram_addr : w_rom_addr;

    logic [1:0] w_gnt;
    logic       w_rom_hit_d;
    logic       w_blocked_d;

`ifdef GSU_ADDR_ARB_EN
    localparam logic [1:0] C_OWN_SNES  = 2'd0;
    localparam logic [1:0] C_WAIT_IDLE = 2'd1;
    localparam logic [1:0] C_OWN_GSU   = 2'd2;

    logic [1:0] w_req;
    assign w_req = {bus.gsu_ram_req, bus.gsu_rom_req};

    // Instance 0 arbitrates ROM, instance 1 arbitrates RAM.
    for (genvar ga = 0; ga < 2; ga++) begin : g_arb
        logic [1:0] state_q;
        logic [1:0] state_d;
        logic       gnt;

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                state_q <= C_OWN_SNES;
            end else begin
                state_q <= state_d;
            end
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                C_OWN_SNES:  if (w_req[ga]) state_d = C_WAIT_IDLE;
                C_WAIT_IDLE: begin
                    if (!w_req[ga]) begin
                        state_d = C_OWN_SNES;
                    end else if (bus.bus_idle) begin
                        state_d = C_OWN_GSU;
                    end
                end
                C_OWN_GSU:   if (!w_req[ga]) state_d = C_OWN_SNES;
                default:     state_d = C_OWN_SNES;
            endcase
        end

        always_comb begin
            gnt = (state_q == C_OWN_GSU);
        end
    end

    assign w_gnt       = {g_arb[1].gnt, g_arb[0].gnt};
    assign w_rom_hit_d = (s1_is_rom_q & ~w_gnt[0]) | (s1_is_sram_q & ~w_gnt[1]);
    assign w_blocked_d = (s1_is_rom_q &  w_gnt[0]) | (s1_is_sram_q &  w_gnt[1]);
`else
    logic w_unused;
    assign w_unused    = &{1'b0, bus.gsu_rom_req, bus.gsu_ram_req, bus.bus_idle};
    assign w_gnt       = 2'b00;
    assign w_rom_hit_d = s1_is_rom_q | s1_is_sram_q;
    assign w_blocked_d = 1'b0;
`endif

    logic               out_valid_q;
    logic [23:0]        rom_addr_q;
    logic               rom_hit_q;
    logic               is_rom_q;
    logic               is_sram_q;
    logic [NUM_WIN-1:0] win_hit_q;
    logic               blocked_q;

    // Result registers only move on a valid stage-1 entry; otherwise they hold.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            rom_addr_q  <= '0;
            rom_hit_q   <= 1'b0;
            is_rom_q    <= 1'b0;
            is_sram_q   <= 1'b0;
            win_hit_q   <= '0;
            blocked_q   <= 1'b0;
        end else begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                rom_addr_q <= rom_addr_d;
                rom_hit_q  <= w_rom_hit_d;
                is_rom_q   <= s1_is_rom_q;
                is_sram_q  <= s1_is_sram_q;
                win_hit_q  <= s1_win_q;
                blocked_q  <= w_blocked_d;
            end
        end
    end

    assign bus.cfg_ack      = cfg_ack_q;
    assign bus.gsu_rom_gnt  = w_gnt[0];
    assign bus.gsu_ram_gnt  = w_gnt[1];
    assign bus.out_valid    = out_valid_q;
    assign bus.rom_addr     = rom_addr_q;
    assign bus.rom_hit      = rom_hit_q;
    assign bus.is_rom       = is_rom_q;
    assign bus.is_saveram   = is_sram_q;
    assign bus.is_writable  = is_sram_q;
    assign bus.win_hit      = win_hit_q;
    assign bus.snes_blocked = blocked_q;

endmodule
`default_nettype wire
